// File: rtl/regfile.sv
// RV32I integer register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              reg1_re_i,
    input  logic [ADDR_W-1:0] reg1_raddr_i,
    output logic [DATA_W-1:0] reg1_rdata_o,
    input  logic              reg2_re_i,
    input  logic [ADDR_W-1:0] reg2_raddr_i,
    output logic [DATA_W-1:0] reg2_rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr_i] = wdata_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        reg1_rdata_o = '0;
        if (!rst_i && reg1_re_i && (reg1_raddr_i != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (reg1_raddr_i == waddr_i)) begin
                reg1_rdata_o = wdata_i;
            end else begin
                reg1_rdata_o = regs_q[reg1_raddr_i];
            end
`else
            reg1_rdata_o = regs_q[reg1_raddr_i];
`endif
        end
    end

    always_comb begin
        reg2_rdata_o = '0;
        if (!rst_i && reg2_re_i && (reg2_raddr_i != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (reg2_raddr_i == waddr_i)) begin
                reg2_rdata_o = wdata_i;
            end else begin
                reg2_rdata_o = regs_q[reg2_raddr_i];
            end
`else
            reg2_rdata_o = regs_q[reg2_raddr_i];
`endif
        end
    end

endmodule
